// File: rtl/rf_access_ctrl.sv
// Four-state sequencer that reads two RF operands, computes a result and writes it back.
// Optional define RF_CTRL_OVF_EN adds a signed-overflow flag output (res_ovf).
module rf_access_ctrl #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_rs1,
    input  logic [AW-1:0] req_rs2,
    input  logic [AW-1:0] req_rd,
    input  logic [DW-1:0] req_imm,
    output logic [AW-1:0] rf_addr1,
    output logic [AW-1:0] rf_addr2,
    input  logic [DW-1:0] rf_data1,
    input  logic [DW-1:0] rf_data2,
    output logic          rf_write,
    output logic [AW-1:0] rf_addr3,
    output logic [DW-1:0] rf_data3,
    output logic          res_valid,
    output logic [DW-1:0] res_data
`ifdef RF_CTRL_OVF_EN
    ,
    output logic          res_ovf
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q;
    logic [AW-1:0] rs1_q, rs2_q, rd_q, addr3_q;
    logic [DW-1:0] imm_q, opa_q, opb_q, result_q;
    logic [DW-1:0] alu_sum, alu_diff, alu_res;
    logic          accept;

    assign accept = req_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= req_op;
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            rd_q  <= req_rd;
            imm_q <= req_imm;
        end
    end

    // Operands are sampled before any write of this op, so rd may alias rs1/rs2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (state_q == READ) begin
            opa_q <= rf_data1;
            opb_q <= rf_data2;
        end
    end

    assign alu_sum  = opa_q + opb_q;
    assign alu_diff = opa_q - opb_q;

    always_comb begin
        alu_res = imm_q;
        case (op_q)
            OP_ADD:  alu_res = alu_sum;
            OP_SUB:  alu_res = alu_diff;
            OP_AND:  alu_res = opa_q & opb_q;
            default: alu_res = imm_q;
        endcase
    end

    // Write address is captured with the result so it holds across the next accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            addr3_q  <= '0;
        end else if (state_q == EXEC) begin
            result_q <= alu_res;
            addr3_q  <= rd_q;
        end
    end

`ifdef RF_CTRL_OVF_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = 1'b0;
        case (op_q)
            OP_ADD:  ovf_d = (opa_q[DW-1] == opb_q[DW-1]) && (alu_sum[DW-1] != opa_q[DW-1]);
            OP_SUB:  ovf_d = (opa_q[DW-1] != opb_q[DW-1]) && (alu_diff[DW-1] != opa_q[DW-1]);
            default: ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == EXEC) begin
            ovf_q <= ovf_d;
        end
    end

    assign res_ovf = ovf_q && (state_q == WB);
`endif

    assign req_ready = (state_q == IDLE);
    assign rf_addr1  = rs1_q;
    assign rf_addr2  = rs2_q;
    assign rf_write  = (state_q == WB);
    assign res_valid = (state_q == WB);
    assign rf_addr3  = addr3_q;
    assign rf_data3  = result_q;
    assign res_data  = result_q;

endmodule

// File: doc/rf_access_ctrl.md
Name: rf_access_ctrl

Overview:
- Initiator/sequencer for the 4x16 two-read/one-write register file.
- Accepts simple register-to-register operations over a valid/ready request port.
- Drives the RF read addresses and captures both operands, then computes the result and issues the single-cycle writeback (addr3/data3/write).
- Sits between instruction decode and the RF; the RF itself is the responder on this interface.

Parameters:
- DW, 16, data width; must match the RF data width.
- AW, 2, register address width; the RF has 2**AW registers.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_op  in  2  00 ADD, 01 SUB, 10 AND, 11 LDI.
- req_rs1  in  AW  source register 1.
- req_rs2  in  AW  source register 2.
- req_rd  in  AW  destination register.
- req_imm  in  DW  immediate; used only by LDI.
- rf_addr1  out  AW  RF read address 1.
- rf_addr2  out  AW  RF read address 2.
- rf_data1  in  DW  RF read data 1; combinational from rf_addr1.
- rf_data2  in  DW  RF read data 2; combinational from rf_addr2.
- rf_write  out  1  RF write enable.
- rf_addr3  out  AW  RF write address.
- rf_data3  out  DW  RF write data.
- res_valid  out  1  one-cycle pulse marking a completed operation.
- res_data  out  DW  result value; valid while res_valid=1.

Behaviour:
- FSM states: IDLE, READ, EXEC, WB.
- Transitions:
  - IDLE -> READ on req_valid && req_ready at posedge. The edge latches op, rs1, rs2, rd and imm.
  - READ -> EXEC unconditionally. The edge captures rf_data1 and rf_data2 into opA and opB.
  - EXEC -> WB unconditionally. The edge registers the result.
  - WB -> IDLE unconditionally. The RF performs its write on this edge.
- rf_addr1 and rf_addr2 are driven from the latched rs1/rs2 in all states; they hold their last value in IDLE.
- Result arithmetic:
  - ADD: opA+opB mod 2**DW; carry discarded.
  - SUB: opA-opB mod 2**DW; borrow discarded.
  - AND: bitwise AND.
  - LDI: imm. Operands are read but ignored.
- WB outputs: rf_write=1, rf_addr3=rd, rf_data3=result, res_valid=1, res_data=result, all for exactly one cycle. rf_write=0 and res_valid=0 in every other state.
- rf_addr3, rf_data3 and res_data hold their last values outside WB.
- req_ready is a combinational decode of state==IDLE and does not depend on req_valid.
- Latency: 3 cycles from the accept edge to the WB cycle. Throughput: one operation per 4 cycles.
- Back-to-back requests: a request held during READ/EXEC/WB is not accepted until the FSM returns to IDLE. The next accept is on the first edge after WB.
- Read-after-write needs no forwarding. The previous write completes on the WB->IDLE edge, before any later READ, so a dependent op reads the updated value.
- rd equal to rs1 or rs2 is legal: operands are captured in READ, before the write.
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All latched fields, opA, opB and result go to 0.
  - rf_write=0, res_valid=0, rf_addr1/2/3=0, rf_data3=0, res_data=0, req_ready=1 while not in reset.
- Reset mid-operation aborts the operation with no RF write. If reset asserts during WB, rf_write drops immediately.
- The RF's own reset is synchronous. The controller guarantees rf_write=0 throughout any reset_n=0 interval.

Optional Feature:
- Macro: RF_CTRL_OVF_EN.
- When defined: adds output port res_ovf (1 bit).
  - Set in WB for ADD/SUB on two's-complement signed overflow of the DW-bit operation.
  - 0 for AND/LDI and outside WB.
  - Registered alongside the result; reset value 0.
- When undefined: the port and its logic are absent; everything else is identical.

Test Plan:
- Reset then LDI rd=1 imm=16'h1234 -> after 3 cycles, WB shows rf_write=1, rf_addr3=1, rf_data3=16'h1234, res_valid=1. The RF model's reg1 then reads 16'h1234.
- LDI r0=16'hFFFF, LDI r1=16'h0001, ADD rd=2 rs1=0 rs2=1 -> res_data=16'h0000 (wrap). With RF_CTRL_OVF_EN, res_ovf=0.
- LDI r0=16'h7FFF, r1=16'h0001, ADD rd=3 rs1=0 rs2=1 -> 16'h8000, res_ovf=1. Then SUB rd=3 rs1=3 rs2=1 -> 16'h7FFF, res_ovf=1.
- Dependent chain with req_valid held high: LDI r2=5, then ADD rd=2 rs1=2 rs2=2 -> second result 16'h000A. req_ready is low for exactly 3 cycles after each accept.
- AND r0=16'hF0F0, r1=16'h3C3C -> 16'h3030, with rd=0 overwriting a source.
- Assert reset_n=0 in EXEC of an ADD -> no rf_write pulse, state IDLE, all outputs 0, target register unchanged.
